// File: rtl/phy_rx_pkg.sv
// Shared definitions for the receive-side SIGNAL field parser: field offsets,
// legal RATE codes and the parser state encoding.
package phy_rx_pkg;

    localparam int unsigned SIGNAL_BITS = 24;
    localparam int unsigned RATE_LSB    = 0;
    localparam int unsigned RATE_W      = 4;
    localparam int unsigned RSV_BIT     = 4;
    localparam int unsigned LENGTH_LSB  = 5;
    localparam int unsigned LENGTH_W    = 12;
    localparam int unsigned PARITY_BIT  = 17;
    localparam int unsigned TAIL_LSB    = 18;
    localparam int unsigned TAIL_W      = 6;
    localparam int unsigned CNT_W       = 15;

    // RATE codes written R1..R4 with R1 in the MSB
    localparam logic [RATE_W-1:0] RATE_6M  = 4'b1101;
    localparam logic [RATE_W-1:0] RATE_9M  = 4'b1111;
    localparam logic [RATE_W-1:0] RATE_12M = 4'b0101;
    localparam logic [RATE_W-1:0] RATE_18M = 4'b0111;
    localparam logic [RATE_W-1:0] RATE_24M = 4'b1001;
    localparam logic [RATE_W-1:0] RATE_36M = 4'b1011;
    localparam logic [RATE_W-1:0] RATE_48M = 4'b0001;
    localparam logic [RATE_W-1:0] RATE_54M = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CHECK,
        ST_SERVICE,
        ST_PAYLOAD
    } state_e;

    function automatic logic rate_is_legal(input logic [RATE_W-1:0] r);
        return r inside {RATE_6M, RATE_9M, RATE_12M, RATE_18M,
                         RATE_24M, RATE_36M, RATE_48M, RATE_54M};
    endfunction

endpackage

// File: rtl/signal_header_check.sv
// Combinational validation of a captured 24-bit SIGNAL field; also unpacks
// RATE (R1 in bit 3) and LENGTH.
module signal_header_check
    import phy_rx_pkg::*;
#(
    parameter int unsigned MAX_LENGTH = 4095,
    parameter bit          CHECK_TAIL = 1'b1
) (
    input  logic [SIGNAL_BITS-1:0] hdr_i,
    output logic                   ok_c_o,
    output logic [RATE_W-1:0]      rate_c_o,
    output logic [LENGTH_W-1:0]    length_c_o
);

    logic rsv_ok;
    logic par_ok;
    logic len_ok;
    logic tail_ok;

    always_comb begin
        rate_c_o   = {hdr_i[RATE_LSB], hdr_i[RATE_LSB+1], hdr_i[RATE_LSB+2], hdr_i[RATE_LSB+3]};
        length_c_o = hdr_i[LENGTH_LSB +: LENGTH_W];
        rsv_ok     = !hdr_i[RSV_BIT];
        par_ok     = !(^hdr_i[PARITY_BIT:RATE_LSB]);
        len_ok     = (length_c_o != '0) && (32'(length_c_o) <= MAX_LENGTH);
        tail_ok    = !CHECK_TAIL || (hdr_i[TAIL_LSB +: TAIL_W] == '0);
        ok_c_o     = rate_is_legal(rate_c_o) && rsv_ok && par_ok && len_ok && tail_ok;
    end

endmodule

// File: rtl/signal_field_parser.sv
// Captures and validates the SIGNAL field, skips SERVICE, then forwards exactly
// LENGTH*8 PSDU bits with a one-cycle registered latency.
module signal_field_parser
    import phy_rx_pkg::*;
#(
    parameter int unsigned MAX_LENGTH   = 4095,
    parameter int unsigned SERVICE_BITS = 16,
    parameter bit          CHECK_TAIL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                in_bit_i,
    input  logic                in_valid_i,
    output logic [RATE_W-1:0]   rate_o,
    output logic [LENGTH_W-1:0] length_o,
    output logic                header_valid_o,
    output logic                header_error_o,
    output logic                out_bit_o,
    output logic                out_valid_o,
    output logic                frame_end_o,
    output logic                busy_o
);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(SIGNAL_BITS - 1);
    localparam logic [CNT_W-1:0] SVC_LAST = CNT_W'(SERVICE_BITS - 1);

    state_e                 state_q, state_d;
    logic [SIGNAL_BITS-1:0] hdr_q, hdr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RATE_W-1:0]      rate_q, rate_d;
    logic [LENGTH_W-1:0]    length_q, length_d;
    logic                   hv_q, hv_d;
    logic                   he_q, he_d;
    logic                   ob_q, ob_d;
    logic                   ov_q, ov_d;
    logic                   fe_q, fe_d;
    logic                   busy_q, busy_d;

    logic [SIGNAL_BITS-1:0] hdr_shift;
    logic                   hdr_ok;
    logic [RATE_W-1:0]      hdr_rate;
    logic [LENGTH_W-1:0]    hdr_length;
    logic [CNT_W-1:0]       pay_last_idx;
    logic                   pay_last;
    logic                   take_start;

    // SIGNAL bit 0 arrives first and ends up in hdr bit 0 after 24 shifts
    assign hdr_shift = {in_bit_i, hdr_q[SIGNAL_BITS-1:1]};

    signal_header_check #(
        .MAX_LENGTH (MAX_LENGTH),
        .CHECK_TAIL (CHECK_TAIL)
    ) u_check (
        .hdr_i      (hdr_shift),
        .ok_c_o     (hdr_ok),
        .rate_c_o   (hdr_rate),
        .length_c_o (hdr_length)
    );

    assign pay_last_idx = {length_q, 3'b000} - CNT_W'(1);
    assign pay_last     = (state_q == ST_PAYLOAD) && in_valid_i && (cnt_q == pay_last_idx);
    // The final payload bit wins over a coincident Start; CHECK never restarts
    assign take_start   = start_i && in_valid_i && (state_q != ST_CHECK) && !pay_last;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        length_d = length_q;
        hv_d     = 1'b0;
        he_d     = 1'b0;
        ob_d     = 1'b0;
        ov_d     = 1'b0;
        fe_d     = 1'b0;

        if (take_start) begin
            hdr_d   = {in_bit_i, {(SIGNAL_BITS-1){1'b0}}};
            cnt_d   = CNT_W'(1);
            state_d = ST_HEADER;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_HEADER: begin
                    if (in_valid_i) begin
                        hdr_d = hdr_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == HDR_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_CHECK;
                            hv_d    = hdr_ok;
                            he_d    = !hdr_ok;
                            if (hdr_ok) begin
                                rate_d   = hdr_rate;
                                length_d = hdr_length;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    cnt_d = '0;
                    if (!hv_q) begin
                        state_d = ST_IDLE;
                    end else if (SERVICE_BITS == 0) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (in_valid_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == SVC_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid_i) begin
                        ob_d  = in_bit_i;
                        ov_d  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (pay_last) begin
                            fe_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hdr_q    <= '0;
            cnt_q    <= '0;
            rate_q   <= '0;
            length_q <= '0;
            hv_q     <= 1'b0;
            he_q     <= 1'b0;
            ob_q     <= 1'b0;
            ov_q     <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            length_q <= length_d;
            hv_q     <= hv_d;
            he_q     <= he_d;
            ob_q     <= ob_d;
            ov_q     <= ov_d;
            fe_q     <= fe_d;
            busy_q   <= busy_d;
        end
    end

    assign rate_o         = rate_q;
    assign length_o       = length_q;
    assign header_valid_o = hv_q;
    assign header_error_o = he_q;
    assign out_bit_o      = ob_q;
    assign out_valid_o    = ov_q;
    assign frame_end_o    = fe_q;
    assign busy_o         = busy_q;

endmodule
